// File: rtl/lvds_align_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lvds_align_pkg
//  Description : Shared types and constants for the LVDS word aligner:
//                lane FSM state encoding, word/offset/counter widths and the
//                barrel-select helper used by every lane.
//  Revision    : 1.0  initial release
// ============================================================================
package lvds_align_pkg;

  localparam int WORD_W   = 8;   // deserialized word width
  localparam int OFFSET_W = 3;   // bit offset 0..7
  localparam int ERRCNT_W = 16;  // optional per-lane mismatch statistic
  localparam int MATCH_W  = 8;   // holds MATCH_CNT up to 255
  localparam int ERRLIM_W = 4;   // holds ERR_LIMIT up to 15
  localparam int SWEEP_W  = 4;   // holds MAX_SWEEPS up to 15

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2,
    FAILED = 2'd3
  } lane_state_t;

  // Pick the word starting k bits into {cur, prev}; bit 0 of prev is the
  // oldest received bit, so a larger k moves the window later in time.
  function automatic logic [WORD_W-1:0] window_select(
    input logic [2*WORD_W-1:0] win,
    input logic [OFFSET_W-1:0] k
  );
    return WORD_W'(win >> k);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lvds_lane_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : lvds_lane_aligner
//  Description : One lane of the word aligner. Keeps the previous word,
//                barrel-selects an 8-bit candidate from {cur, prev} at the
//                current offset, registers it as aligned output and runs the
//                IDLE/SEARCH/LOCKED/FAILED training FSM.
//  Ports       : rxclk_div, reset (async, active high), bitslip_finished,
//                train_en, train_pattern[7:0], rx_word[7:0] in;
//                aligned_word[7:0], locked, failed, offset[2:0] out.
//                With LVDS_ALIGN_ERRCNT_EN: err_clear in, err_count[15:0] out.
//  Revision    : 1.0  initial release
// ============================================================================
module lvds_lane_aligner
  import lvds_align_pkg::*;
#(
  parameter int MATCH_CNT  = 16,
  parameter int ERR_LIMIT  = 4,
  parameter int MAX_SWEEPS = 4
) (
  input  logic                rxclk_div,
  input  logic                reset,
  input  logic                bitslip_finished,
  input  logic                train_en,
  input  logic [WORD_W-1:0]   train_pattern,
  input  logic [WORD_W-1:0]   rx_word,
`ifdef LVDS_ALIGN_ERRCNT_EN
  input  logic                err_clear,
  output logic [ERRCNT_W-1:0] err_count,
`endif
  output logic [WORD_W-1:0]   aligned_word,
  output logic                locked,
  output logic                failed,
  output logic [OFFSET_W-1:0] offset
);

  localparam logic [MATCH_W-1:0]  C_MATCH_LAST = MATCH_W'(MATCH_CNT - 1);
  localparam logic [MATCH_W-1:0]  C_MATCH_FULL = MATCH_W'(MATCH_CNT);
  localparam logic [ERRLIM_W-1:0] C_ERR_LAST   = ERRLIM_W'(ERR_LIMIT - 1);
  localparam logic [SWEEP_W-1:0]  C_SWEEP_LAST = SWEEP_W'(MAX_SWEEPS - 1);
  localparam logic [SWEEP_W-1:0]  C_SWEEP_FULL = SWEEP_W'(MAX_SWEEPS);
  localparam logic [OFFSET_W-1:0] C_OFFSET_MAX = '1;

  lane_state_t         r_state,     w_state_nxt;
  logic [OFFSET_W-1:0] r_offset,    w_offset_nxt;
  logic [MATCH_W-1:0]  r_match_cnt, w_match_nxt;
  logic [ERRLIM_W-1:0] r_err_cnt,   w_err_nxt;
  logic [SWEEP_W-1:0]  r_sweep_cnt, w_sweep_nxt;
  logic [WORD_W-1:0]   r_prev;
  logic [WORD_W-1:0]   r_aligned;
  logic [WORD_W-1:0]   w_cand;
  logic                w_match;

  assign w_cand  = window_select({rx_word, r_prev}, r_offset);
  assign w_match = (w_cand == train_pattern);

  // Datapath runs in every state; only the top-level valid qualifies it.
  always_ff @(posedge rxclk_div or posedge reset) begin
    if (reset) begin
      r_prev    <= '0;
      r_aligned <= '0;
    end else begin
      r_prev    <= rx_word;
      r_aligned <= w_cand;
    end
  end

  always_ff @(posedge rxclk_div or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_offset    <= '0;
      r_match_cnt <= '0;
      r_err_cnt   <= '0;
      r_sweep_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_offset    <= w_offset_nxt;
      r_match_cnt <= w_match_nxt;
      r_err_cnt   <= w_err_nxt;
      r_sweep_cnt <= w_sweep_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_offset_nxt = r_offset;
    w_match_nxt  = r_match_cnt;
    w_err_nxt    = r_err_cnt;
    w_sweep_nxt  = r_sweep_cnt;

    if (!bitslip_finished) begin
      // Deserializer not ready: everything back to a clean IDLE.
      w_state_nxt  = IDLE;
      w_offset_nxt = '0;
      w_match_nxt  = '0;
      w_err_nxt    = '0;
      w_sweep_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt  = SEARCH;
          w_offset_nxt = '0;
        end
        SEARCH: begin
          if (train_en) begin
            if (w_match) begin
              if (r_match_cnt >= C_MATCH_LAST) begin
                w_match_nxt = C_MATCH_FULL;
                w_err_nxt   = '0;
                w_state_nxt = LOCKED;
              end else begin
                w_match_nxt = r_match_cnt + 1'b1;
              end
            end else begin
              w_match_nxt  = '0;
              w_offset_nxt = r_offset + 1'b1;  // wraps 7 -> 0
              if (r_offset == C_OFFSET_MAX) begin
                if (r_sweep_cnt >= C_SWEEP_LAST) begin
                  w_sweep_nxt = C_SWEEP_FULL;
                  w_state_nxt = FAILED;
                end else begin
                  w_sweep_nxt = r_sweep_cnt + 1'b1;
                end
              end
            end
          end
        end
        LOCKED: begin
          if (train_en) begin
            if (!w_match) begin
              if (r_err_cnt >= C_ERR_LAST) begin
                // Re-search starting from the offset that used to work.
                w_state_nxt = SEARCH;
                w_match_nxt = '0;
                w_err_nxt   = '0;
              end else begin
                w_err_nxt = r_err_cnt + 1'b1;
              end
            end else begin
              w_err_nxt = '0;
            end
          end
        end
        FAILED: begin
          w_state_nxt = FAILED;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

`ifdef LVDS_ALIGN_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_err_count;

  // Long-term statistic: survives re-search, only reset or err_clear zero it.
  always_ff @(posedge rxclk_div or posedge reset) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (err_clear) begin
      r_err_count <= '0;
    end else if ((r_state == LOCKED) && train_en && !w_match &&
                 (r_err_count != {ERRCNT_W{1'b1}})) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign err_count = r_err_count;
`endif

  assign aligned_word = r_aligned;
  assign locked       = (r_state == LOCKED);
  assign failed       = (r_state == FAILED);
  assign offset       = r_offset;

endmodule
`default_nettype wire

// File: rtl/lvds_word_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : lvds_word_aligner
//  Description : D-lane word aligner behind the 1:8 DDR deserializer, in the
//                rxclk_div domain. Each lane finds the bit offset of a known
//                training word and emits word-aligned data; aligned_valid is
//                high while every lane is locked.
//  Ports       : rxclk_div, reset (async, active high), bitslip_finished,
//                rx_data[8*D-1:0], train_en, train_pattern[7:0] in;
//                aligned_data[8*D-1:0], aligned_valid, lane_locked[D-1:0],
//                lane_failed[D-1:0], bit_offset[3*D-1:0] out.
//  Option      : `define LVDS_ALIGN_ERRCNT_EN adds err_clear (in) and
//                err_count[16*D-1:0] (out), per-lane locked-mismatch counts.
//  Revision    : 1.0  initial release
// ============================================================================
module lvds_word_aligner
  import lvds_align_pkg::*;
#(
  parameter int D          = 8,
  parameter int MATCH_CNT  = 16,
  parameter int ERR_LIMIT  = 4,
  parameter int MAX_SWEEPS = 4
) (
  input  logic                  rxclk_div,
  input  logic                  reset,
  input  logic                  bitslip_finished,
  input  logic [WORD_W*D-1:0]   rx_data,
  input  logic                  train_en,
  input  logic [WORD_W-1:0]     train_pattern,
`ifdef LVDS_ALIGN_ERRCNT_EN
  input  logic                  err_clear,
  output logic [ERRCNT_W*D-1:0] err_count,
`endif
  output logic [WORD_W*D-1:0]   aligned_data,
  output logic                  aligned_valid,
  output logic [D-1:0]          lane_locked,
  output logic [D-1:0]          lane_failed,
  output logic [OFFSET_W*D-1:0] bit_offset
);

  logic r_valid;

  for (genvar i = 0; i < D; i++) begin : g_lane
    lvds_lane_aligner #(
      .MATCH_CNT  (MATCH_CNT),
      .ERR_LIMIT  (ERR_LIMIT),
      .MAX_SWEEPS (MAX_SWEEPS)
    ) u_lane (
      .rxclk_div        (rxclk_div),
      .reset            (reset),
      .bitslip_finished (bitslip_finished),
      .train_en         (train_en),
      .train_pattern    (train_pattern),
      .rx_word          (rx_data[WORD_W*i +: WORD_W]),
`ifdef LVDS_ALIGN_ERRCNT_EN
      .err_clear        (err_clear),
      .err_count        (err_count[ERRCNT_W*i +: ERRCNT_W]),
`endif
      .aligned_word     (aligned_data[WORD_W*i +: WORD_W]),
      .locked           (lane_locked[i]),
      .failed           (lane_failed[i]),
      .offset           (bit_offset[OFFSET_W*i +: OFFSET_W])
    );
  end

  // Valid rises one cycle after the last lane locks, but the AND with the
  // live lock bits makes it fall in the same cycle any lane drops out.
  always_ff @(posedge rxclk_div or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= (&lane_locked) & bitslip_finished;
    end
  end

  assign aligned_valid = r_valid & (&lane_locked);

endmodule
`default_nettype wire
